vector_inner_product_responder: RTL

// - Responder end of the row/column/result stb-ack protocol used by the matrix multiplier.
// - Captures a p-word row and a p-word column over two independent four-phase handshakes.
// - Computes their inner product serially, one multiply-accumulate per cycle.
// - Presents the result on a third four-phase handshake; one instance serves one row of C.

---
 rtl/matrix_pkg.sv | 13 +
 rtl/word_mac.sv | 32 +++
 rtl/vector_inner_product_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Definitions shared by the matrix multiplier controller and its inner-product responders.
package matrix_pkg;

  localparam int WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;

  // Controller state encodings; the multiplier's controller decodes the same values.
  localparam logic [1:0] ST_GET = 2'd0;
  localparam logic [1:0] ST_MAC = 2'd1;
  localparam logic [1:0] ST_OUT = 2'd2;

endpackage

// File: rtl/word_mac.sv
// Registered multiply-accumulate, modulo 2^WORD_WIDTH; exposes the running sum for the current step.
module word_mac
  import matrix_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  en,
  input  word_t a,
  input  word_t b,
  output word_t sum
);

  word_t acc;
  word_t product;

  // Keeping only the low word gives two's-complement wrap for signed operands as well.
  assign product = a * b;
  assign sum     = acc + product;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/vector_inner_product_responder.sv
// Responder for one row of C: captures a row and a column over four-phase handshakes,
// accumulates their inner product one word per cycle, and offers the result on a third handshake.
module vector_inner_product_responder
  import matrix_pkg::*;
#(
  parameter int p = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [p*WORD_WIDTH-1:0] row,
  input  logic                    row_i_stb,
  output logic                    row_i_ack,
  input  logic [p*WORD_WIDTH-1:0] column,
  input  logic                    column_i_stb,
  output logic                    column_i_ack,
  output logic [WORD_WIDTH-1:0]   out,
  output logic                    out_o_stb,
  input  logic                    out_o_ack
);

  localparam int K_W   = $clog2(p + 1);
  localparam int IDX_W = (p > 1) ? $clog2(p) : 1;

  logic [1:0]                   state;
  logic [K_W-1:0]               k;
  logic [IDX_W-1:0]             idx;
  logic [p-1:0][WORD_WIDTH-1:0] row_q;
  logic [p-1:0][WORD_WIDTH-1:0] column_q;
  logic                         row_held;
  logic                         column_held;
  logic                         row_take;
  logic                         column_take;
  logic                         start;
  logic                         last_step;
  logic                         mac_en;
  word_t                        sum;

  // An operand is taken only once its previous handshake has fully returned to idle.
  assign row_take    = row_i_stb    && !row_held    && !row_i_ack;
  assign column_take = column_i_stb && !column_held && !column_i_ack;

  // Starting on the capture edge itself keeps the result latency at exactly p edges.
  assign start     = (state == ST_GET) && (row_held || row_take) && (column_held || column_take);
  assign last_step = (state == ST_MAC) && (k == K_W'(p - 1));
  assign mac_en    = (state == ST_MAC);
  assign idx       = k[IDX_W-1:0];

  // NOTE: operand registers are reset too, so no stale words survive an aborted transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q        <= '0;
      column_q     <= '0;
      row_held     <= 1'b0;
      column_held  <= 1'b0;
      row_i_ack    <= 1'b0;
      column_i_ack <= 1'b0;
    end else begin
      if (row_take) begin
        row_q     <= row;
        row_held  <= 1'b1;
        row_i_ack <= 1'b1;
      end else begin
        if (row_i_ack && !row_i_stb) row_i_ack <= 1'b0;
        if (last_step)               row_held  <= 1'b0;
      end

      if (column_take) begin
        column_q     <= column;
        column_held  <= 1'b1;
        column_i_ack <= 1'b1;
      end else begin
        if (column_i_ack && !column_i_stb) column_i_ack <= 1'b0;
        if (last_step)                     column_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_GET;
      k         <= '0;
      out       <= '0;
      out_o_stb <= 1'b0;
    end else begin
      case (state)
        ST_GET: begin
          if (start) begin
            state <= ST_MAC;
            k     <= '0;
          end
        end
        ST_MAC: begin
          if (last_step) begin
            state     <= ST_OUT;
            out       <= sum;
            // A consumer still acknowledging the previous result holds off the strobe.
            out_o_stb <= !out_o_ack;
          end else begin
            k <= k + K_W'(1);
          end
        end
        ST_OUT: begin
          if (out_o_stb) begin
            if (out_o_ack) begin
              out_o_stb <= 1'b0;
              state     <= ST_GET;
            end
          end else if (!out_o_ack) begin
            out_o_stb <= 1'b1;
          end
        end
        default: state <= ST_GET;
      endcase
    end
  end

  word_mac u_mac (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (mac_en),
    .a   (row_q[idx]),
    .b   (column_q[idx]),
    .sum (sum)
  );

endmodule
